// File: rtl/instr_encoder_loader_if.sv
// Bundle of the field-level encoder input, write-address control and the
// instruction-memory write handshake. The producer side uses master; the loader uses slave.
interface instr_encoder_loader_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_cond;
    logic [1:0]        in_mode;
    logic              in_imm;
    logic [3:0]        in_op;
    logic              in_s;
    logic [3:0]        in_rn;
    logic [3:0]        in_rd;
    logic [11:0]       in_operand;
    logic [23:0]       in_offset;
    logic              base_load;
    logic [ADDR_W-1:0] base_addr;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              wr_ready;
    logic [CW-1:0]     fifo_count;
    logic              err;
    logic [7:0]        err_count;

    modport master (
        output in_valid, in_cond, in_mode, in_imm, in_op, in_s, in_rn, in_rd,
               in_operand, in_offset, base_load, base_addr, wr_ready,
        input  in_ready, wr_en, wr_addr, wr_data, fifo_count, err, err_count
    );

    modport slave (
        input  in_valid, in_cond, in_mode, in_imm, in_op, in_s, in_rn, in_rd,
               in_operand, in_offset, base_load, base_addr, wr_ready,
        output in_ready, wr_en, wr_addr, wr_data, fifo_count, err, err_count
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// Packs field-level instruction descriptions into 32-bit words, buffers them
// in a FIFO and streams them to instruction memory at an auto-incrementing byte address.
module instr_encoder_loader #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    instr_encoder_loader_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);

    logic [PW:0]       wr_ptr;
    logic [PW:0]       rd_ptr;
    logic [PW:0]       count;
    logic [31:0]       mem [DEPTH];
    logic              full;
    logic              empty;
    logic              accept;
    logic              push;
    logic              pop;
    logic              legal;
    logic [31:0]       word;
    logic [ADDR_W-1:0] addr;
    logic              err_q;
    logic [7:0]        err_cnt;

    assign count  = wr_ptr - rd_ptr;
    assign full   = (count == (PW+1)'(DEPTH));
    assign empty  = (count == '0);
    assign accept = bus.in_valid && !full;
    assign push   = accept && legal;
    assign pop    = !empty && bus.wr_ready;

    always_comb begin
        word  = '0;
        legal = 1'b0;
        case (bus.in_mode)
            2'b00: begin
                legal = bus.in_op inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101,
                                          4'b0110, 4'b1000, 4'b1010, 4'b1100, 4'b1101,
                                          4'b1111};
                word = {bus.in_cond, 2'b00, bus.in_imm, bus.in_op, bus.in_s,
                        bus.in_rn, bus.in_rd, bus.in_operand};
                // TST/CMP only set flags: S forced on, Rd forced to zero
                if (bus.in_op == 4'b1000 || bus.in_op == 4'b1010) begin
                    word[20]    = 1'b1;
                    word[15:12] = 4'b0000;
                end
            end
            2'b01: begin
                legal = 1'b1;
                word  = {bus.in_cond, 2'b01, bus.in_imm, 4'b0100, bus.in_s,
                         bus.in_rn, bus.in_rd, bus.in_operand};
            end
            2'b10: begin
                legal = 1'b1;
                word  = {bus.in_cond, 3'b101, 1'b0, bus.in_offset};
            end
            default: begin
                legal = 1'b0;
                word  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            addr    <= '0;
            err_q   <= 1'b0;
            err_cnt <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[PW-1:0]] <= word;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            // base_load wins; a write in the same cycle already used the old address
            if (bus.base_load)
                addr <= bus.base_addr;
            else if (pop)
                addr <= addr + ADDR_W'(4);
            err_q <= accept && !legal;
            if (accept && !legal && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
    end

    assign bus.in_ready   = !full;
    assign bus.wr_en      = !empty;
    assign bus.wr_data    = mem[rd_ptr[PW-1:0]];
    assign bus.wr_addr    = addr;
    assign bus.fifo_count = count;
    assign bus.err        = err_q;
    assign bus.err_count  = err_cnt;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomized and directed bench for instr_encoder_loader against a queue-based
// reference model of the encoder, FIFO, address counter and error counter.
module tb_instr_encoder_loader;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;

    logic clk;
    logic rst;

    instr_encoder_loader_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

    instr_encoder_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    bit [31:0] q[$];
    bit [31:0] m_addr;
    int        m_errcnt;
    bit        m_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference encoder: {legal, word} built from the field rules with plain arithmetic
    function automatic bit [32:0] ref_encode(int cond, int mode, int imm, int op, int s,
                                             int rn, int rd, int operand, int offset);
        longint w;
        bit     ok;
        int     legal_ops[11] = '{0, 1, 2, 4, 5, 6, 8, 10, 12, 13, 15};
        ok = 0;
        w  = 0;
        if (mode == 0) begin
            foreach (legal_ops[i]) if (legal_ops[i] == op) ok = 1;
            if (op == 8 || op == 10) begin
                s  = 1;
                rd = 0;
            end
            w = cond * 2**28 + imm * 2**25 + op * 2**21 + s * 2**20
              + rn * 2**16 + rd * 2**12 + operand;
        end else if (mode == 1) begin
            ok = 1;
            w  = cond * 2**28 + 1 * 2**26 + imm * 2**25 + 4 * 2**21 + s * 2**20
               + rn * 2**16 + rd * 2**12 + operand;
        end else if (mode == 2) begin
            ok = 1;
            w  = cond * 2**28 + 5 * 2**25 + offset;
        end
        return {ok, w[31:0]};
    endfunction

    task automatic drive(input bit valid, input int cond, input int mode, input int imm,
                         input int op, input int s, input int rn, input int rd,
                         input int operand, input int offset);
        bus.in_valid   = valid;
        bus.in_cond    = 4'(cond);
        bus.in_mode    = 2'(mode);
        bus.in_imm     = 1'(imm);
        bus.in_op      = 4'(op);
        bus.in_s       = 1'(s);
        bus.in_rn      = 4'(rn);
        bus.in_rd      = 4'(rd);
        bus.in_operand = 12'(operand);
        bus.in_offset  = 24'(offset);
    endtask

    task automatic compare_all();
        check("in_ready", bus.in_ready, q.size() < DEPTH);
        check("wr_en", bus.wr_en, q.size() != 0);
        if (q.size() != 0) check("wr_data", bus.wr_data, q[0]);
        check("wr_addr", bus.wr_addr, m_addr);
        check("fifo_count", bus.fifo_count, q.size());
        check("err", bus.err, m_err);
        check("err_count", bus.err_count, m_errcnt);
    endtask

    // One clock: model predicts from the inputs held across the edge, then compares
    task automatic tick();
        bit        fire;
        bit        acc;
        bit [32:0] e;
        fire = (q.size() != 0) && bus.wr_ready;
        acc  = bus.in_valid && (q.size() < DEPTH);
        e    = ref_encode(int'(bus.in_cond), int'(bus.in_mode), int'(bus.in_imm),
                          int'(bus.in_op), int'(bus.in_s), int'(bus.in_rn),
                          int'(bus.in_rd), int'(bus.in_operand), int'(bus.in_offset));
        @(posedge clk);
        if (fire) void'(q.pop_front());
        if (acc && e[32]) q.push_back(e[31:0]);
        if (bus.base_load) m_addr = bus.base_addr;
        else if (fire) m_addr = m_addr + 32'd4;
        m_err = acc && !e[32];
        if (m_err && m_errcnt < 255) m_errcnt++;
        #1;
        compare_all();
    endtask

    task automatic model_reset();
        q.delete();
        m_addr   = '0;
        m_errcnt = 0;
        m_err    = 0;
    endtask

    bit [31:0] a;

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.base_load = 0;
        bus.base_addr = '0;
        bus.wr_ready  = 0;
        model_reset();
        rst = 1'b0;
        #12;
        check("rst_wr_en", bus.wr_en, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_fifo_count", bus.fifo_count, 0);
        check("rst_wr_addr", bus.wr_addr, 0);
        check("rst_wr_data", bus.wr_data, 0);
        check("rst_err", bus.err, 0);
        check("rst_err_count", bus.err_count, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // ADD
        bus.wr_ready  = 1;
        bus.base_load = 1;
        bus.base_addr = 32'h100;
        tick();
        bus.base_load = 0;
        drive(1, 14, 0, 0, 4, 0, 1, 2, 3, 0);
        tick();
        check("add_data", bus.wr_data, 32'hE0812003);
        check("add_addr", bus.wr_addr, 32'h100);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check("add_next_addr", bus.wr_addr, 32'h104);

        // CMP with forced S and Rd
        drive(1, 14, 0, 0, 10, 0, 3, 7, 4, 0);
        tick();
        check("cmp_data", bus.wr_data, 32'hE1530004);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // LDR then branch back-to-back
        a = bus.wr_addr;
        drive(1, 14, 1, 0, 0, 1, 0, 5, 8, 0);
        tick();
        check("ldr_data", bus.wr_data, 32'hE4905008);
        check("ldr_addr", bus.wr_addr, a);
        drive(1, 14, 2, 0, 0, 0, 0, 0, 0, 24'hFFFFFE);
        tick();
        check("b_data", bus.wr_data, 32'hEAFFFFFE);
        check("b_addr", bus.wr_addr, a + 32'd4);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // Illegal mode and opcode
        drive(1, 14, 3, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check("ill1_err", bus.err, 1);
        drive(1, 14, 0, 0, 3, 0, 1, 2, 3, 0);
        tick();
        check("ill2_err", bus.err, 1);
        check("ill2_wr_en", bus.wr_en, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check("ill_err_low", bus.err, 0);
        check("ill_err_count", bus.err_count, 2);
        check("ill_fifo_count", bus.fifo_count, 0);

        // Backpressure with base_load on the 2nd write
        bus.wr_ready  = 0;
        bus.base_load = 1;
        bus.base_addr = 32'h200;
        tick();
        bus.base_load = 0;
        for (int i = 0; i < 5; i++) begin
            drive(1, 14, 0, 0, 4, 0, 1, i, 16 + i, 0);
            tick();
        end
        check("bp_in_ready", bus.in_ready, 0);
        check("bp_count", bus.fifo_count, 4);
        check("bp_head", bus.wr_data, 32'hE0810010);
        check("bp_addr", bus.wr_addr, 32'h200);
        bus.wr_ready = 1;
        tick();
        check("bp_w1_addr_next", bus.wr_addr, 32'h204);
        bus.base_load = 1;
        bus.base_addr = 32'h800;
        tick();
        bus.base_load = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("bp_w3_addr", bus.wr_addr, 32'h800);
        check("bp_w3_data", bus.wr_data, 32'hE0812012);
        repeat (4) tick();
        check("bp_drained", bus.fifo_count, 0);

        // Mid-stream reset with 3 words buffered
        bus.wr_ready = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 2, 0, 0, 0, 0, 0, 0, i);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.wr_ready = 1;
        #2 rst = 1'b0;
        #1;
        model_reset();
        check("mrst_wr_en", bus.wr_en, 0);
        check("mrst_count", bus.fifo_count, 0);
        check("mrst_addr", bus.wr_addr, 0);
        check("mrst_errcnt", bus.err_count, 0);
        @(posedge clk); #1;
        compare_all();
        rst = 1'b1;
        @(posedge clk); #1;

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            int mode;
            int r;
            r    = $urandom_range(0, 9);
            mode = (r < 4) ? 0 : (r < 7) ? 1 : (r < 9) ? 2 : 3;
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 15), mode, $urandom_range(0, 1),
                  $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 15),
                  $urandom_range(0, 15), $urandom_range(0, 4095), $urandom_range(0, 24'hFFFFFF));
            bus.wr_ready  = $urandom_range(0, 2) != 0;
            bus.base_load = $urandom_range(0, 19) == 0;
            bus.base_addr = $urandom;
            tick();
        end

        // Error counter saturation
        bus.base_load = 0;
        drive(1, 0, 3, 0, 0, 0, 0, 0, 0, 0);
        repeat (260) tick();
        check("sat_err_count", bus.err_count, 255);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Encoder counterpart to the control-unit decoder: takes field-level instruction descriptions (cond, mode, opcode, S/L, registers, operand/offset) and packs them into 32-bit instruction words in our simplified ARM format.
- Buffers the encoded words in a FIFO and streams them into instruction memory through a write handshake, with an auto-incrementing byte address.
- Used for program loading and for self-checking benches of the fetch/decode path.

Parameters:
- DEPTH, 4, FIFO entries (power of two, at least 2)
- ADDR_W, 32, width of the instruction-memory byte address

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  asynchronous reset, active-low; clears all state immediately
- in_valid  input  1  field set presented
- in_ready  output  1  encoder can accept; equals !full
- in_cond  input  4  condition field
- in_mode  input  2  00 data-processing, 01 memory, 10 branch, 11 illegal
- in_imm  input  1  I bit (modes 00/01)
- in_op  input  4  opcode (mode 00 only)
- in_s  input  1  S bit (mode 00), L bit (mode 01: 1 = load, 0 = store)
- in_rn  input  4  Rn field
- in_rd  input  4  Rd field
- in_operand  input  12  shifter operand / memory offset
- in_offset  input  24  signed branch offset
- base_load  input  1  load write address
- base_addr  input  ADDR_W  new write address
- wr_en  output  1  head word valid; equals !empty
- wr_addr  output  ADDR_W  byte address for the current head word
- wr_data  output  32  head word
- wr_ready  input  1  memory accepts the word
- fifo_count  output  log2(DEPTH)+1  occupancy
- err  output  1  one-cycle pulse on an illegal accept
- err_count  output  8  count of illegal accepts, saturating

Behaviour:
- Reset (rst = 0, asynchronous) clears:
  - FIFO pointers, so fifo_count = 0, wr_en = 0 and in_ready = 1.
  - wr_addr = 0, err = 0, err_count = 0.
  - wr_data = 0.
- Accept: a word is accepted on the edge where in_valid && in_ready. Encoding is combinational and the result is written into the FIFO tail in that same edge.
- Mode 00 (data-processing) encoding:
  - Word layout: [31:28] cond, [27:26] 00, [25] I, [24:21] op, [20] S, [19:16] Rn, [15:12] Rd, [11:0] operand.
  - Legal opcodes: 0000, 0001, 0010, 0100, 0101, 0110, 1000, 1010, 1100, 1101, 1111. Any other opcode is illegal.
  - Opcodes 1000 and 1010 (TST/CMP): S is forced to 1 and Rd is forced to 0.
- Mode 01 (memory) encoding:
  - [27:26] = 01, [25] = I, [24:21] forced to 0100, [20] = L.
  - Rn, Rd and [11:0] = in_operand as in mode 00.
- Mode 10 (branch) encoding: [31:28] cond, [27:25] = 101, [24] = 0, [23:0] = in_offset.
- Mode 11: illegal.
- Illegal inputs are still consumed (in_ready unaffected) but are not pushed.
  - err pulses high for exactly the cycle after the accept.
  - err_count increments and saturates at 255.
- Write side:
  - wr_en and wr_data reflect the registered FIFO head.
  - A write fires on the edge where wr_en && wr_ready: the head is popped and wr_addr += 4, wrapping modulo 2^ADDR_W.
  - wr_en must not drop while wr_ready = 0, and wr_data/wr_addr must stay stable under stall.
- Latency: a word accepted at edge N appears on wr_en at edge N. There is no bypass into an empty FIFO.
- Full FIFO: in_ready = 0, so no push, even if a pop happens in the same cycle.
- Push and pop in the same cycle (not full, not empty): fifo_count is unchanged.
- base_load:
  - wr_addr <= base_addr; base_load takes priority over the +4 increment.
  - If a write fires in the same cycle, that write uses the old wr_addr.
  - FIFO contents are untouched.
- Reset asserted mid-stream discards all buffered words. There is no partial-write state.

Test Plan:
- ADD, one word:
  - Stimulus: base_load 0x100; then cond E, mode 00, I 0, op 0100, S 0, Rn 1, Rd 2, operand 0x003, wr_ready = 1.
  - Required: wr_data 0xE0812003 at wr_addr 0x100; next wr_addr 0x104.
- CMP with forced fields:
  - Stimulus: op 1010, S 0, Rn 3, Rd 7, operand 0x004, cond E, I 0.
  - Required: 0xE1530004 (S forced to 1, Rd forced to 0).
- LDR and branch, back-to-back:
  - Stimulus: LDR (mode 01, L 1, Rn 0, Rd 5, offset 0x008), then branch (cond E, offset 0xFFFFFE).
  - Required: 0xE4905008 at addr A, then 0xEAFFFFFE at addr A+4.
- Illegal inputs:
  - Stimulus: mode 11, then mode 00 with op 0011.
  - Required: two err pulses, err_count = 2, no wr_en, fifo_count stays 0.
- Backpressure:
  - Stimulus: DEPTH = 4, wr_ready = 0, five valid words offered.
  - Required: in_ready drops after the 4th, fifo_count = 4, head word and address stable.
  - Stimulus: release wr_ready.
  - Required: writes at base, +4, +8, +12, then the 5th word.
  - Stimulus: base_load in the same cycle as the 2nd write.
  - Required: the 2nd write uses the old address; the 3rd write goes to base_addr.
- Mid-stream reset:
  - Stimulus: assert rst with 3 words buffered, asynchronously between edges.
  - Required: wr_en = 0, fifo_count = 0, wr_addr = 0, err_count = 0 immediately, with no write completing after reset.
